instr_prefetch_queue: RTL and testbench

- Instruction fetch front-end between the MMU instruction port and the controlpath.
- Drives the MMU instruction address and accepts words when the MMU is not stalling.
- Buffers up to DEPTH instructions, each tagged with its PC and fault bit.
- Presents the head entry to the controlpath, which consumes it with pc_inc. A redirect (branch or jump) flushes the queue and restarts fetch at a new PC.

---
 rtl/instr_prefetch_queue.sv | 140 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch front-end between the MMU instruction
// port and the controlpath. Fetches sequentially from fetch_addr, buffers up to
// DEPTH {word, pc, fault} entries and presents the head entry. A redirect flushes
// the queue and restarts fetch at redirect_pc. A faulting fetch halts fetch until
// the next redirect.
//
// Optional build macro PREFETCH_STATS_EN adds stall_count and flush_count
// saturating statistics outputs.

module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] fetch_addr,
    input  logic [31:0] mmu_instr,
    input  logic        wait_instr,
    input  logic        instr_segv,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pc_inc,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_fault
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      STEP     = 32'(PC_STEP);

    // Entry storage, split into parallel arrays indexed by pointer.
    logic [31:0] word_mem  [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic        fault_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             halted;

    logic not_full;
    logic accept;
    logic pop;

    // Handshake decode: full is judged on the pre-pop count; redirect blocks both.
    always_comb begin
        not_full = (count < FULL_CNT);
        accept   = !wait_instr && !halted && not_full && !redirect;
        pop      = pc_inc && instr_valid && !redirect;
    end

    // Entry write port; contents are only observed through count, so no reset.
    // NOTE: storage arrays are left unreset so they map onto plain RAM/flops
    // without a reset tree; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_mem[wr_ptr]  <= mmu_instr;
            pc_mem[wr_ptr]    <= fetch_addr;
            fault_mem[wr_ptr] <= instr_segv;
        end
    end

    // Pointer, occupancy, halt and fetch-address control; redirect has priority.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            fetch_addr <= RESET_PC;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            fetch_addr <= redirect_pc;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (instr_segv) begin
                    halted <= 1'b1;
                end else begin
                    fetch_addr <= fetch_addr + STEP;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry presentation; reads as zero when the queue is empty.
    // NOTE: every output gets a default before the conditional so no latch
    // is inferred.
    always_comb begin
        instr_valid = (count != '0);
        instruction = '0;
        instr_pc    = '0;
        instr_fault = 1'b0;
        if (instr_valid) begin
            instruction = word_mem[rd_ptr];
            instr_pc    = pc_mem[rd_ptr];
            instr_fault = fault_mem[rd_ptr];
        end
    end

`ifdef PREFETCH_STATS_EN
    // Saturating statistics: MMU stall cycles that blocked a wanted fetch, and redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (wait_instr && !halted && not_full && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed bench for instr_prefetch_queue (DEPTH=4).
// The MMU responder returns word = address ^ 32'hA5A5_0000 and can be told to
// fault on one chosen address.

module tb_instr_prefetch_queue;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic [31:0] mmu_instr;
    logic        wait_instr;
    logic        instr_segv;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_inc;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_count;
    logic [15:0] flush_count;
`endif

    logic        seg_en;
    logic [31:0] seg_pc;

    int n_checks = 0;
    int n_errors = 0;

    instr_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_addr  (fetch_addr),
        .mmu_instr   (mmu_instr),
        .wait_instr  (wait_instr),
        .instr_segv  (instr_segv),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_inc      (pc_inc),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_fault (instr_fault)
`ifdef PREFETCH_STATS_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MMU responder
    always_comb begin
        mmu_instr  = fetch_addr ^ XOR_KEY;
        instr_segv = seg_en && (fetch_addr == seg_pc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_word"}, instruction, pc ^ XOR_KEY);
        check({tag, "_fault"}, 32'(instr_fault), 32'(fault));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_word"}, instruction, 32'd0);
        check({tag, "_pc"}, instr_pc, 32'd0);
        check({tag, "_fault"}, 32'(instr_fault), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        wait_instr  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        pc_inc      = 1'b0;
        seg_en      = 1'b0;
        seg_pc      = 32'd0;

        // Reset state
        #2;
        check_empty("rst");
        check("rst_fetch_addr", fetch_addr, 32'h0);

        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        wait_instr = 1'b0;

        // Fill: first word visible after one edge, then queue fills to 4
        step();
        check_head("fill1", 32'h0, 1'b0);
        check("fill1_fetch_addr", fetch_addr, 32'h4);
        step(5);
        check_head("full", 32'h0, 1'b0);
        check("full_fetch_addr", fetch_addr, 32'h10);

        // Pop while full: no push that cycle, push on the next
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        check_head("popfull", 32'h4, 1'b0);
        check("popfull_fetch_addr", fetch_addr, 32'h10);
        step();
        check("refill_fetch_addr", fetch_addr, 32'h14);

        // MMU stall for 5 cycles: address frozen
        wait_instr = 1'b1;
        step(5);
        check("stall_fetch_addr", fetch_addr, 32'h14);

        // Drain during stall: exactly 4 entries 0x4..0x10 present
        check_head("drain0", 32'h4, 1'b0);
        pc_inc = 1'b1;
        step();
        check_head("drain1", 32'h8, 1'b0);
        step();
        check_head("drain2", 32'hC, 1'b0);
        step();
        check_head("drain3", 32'h10, 1'b0);
        step();
        check_empty("drain4");
        // pc_inc while empty: no underflow
        step();
        check_empty("underflow");
        pc_inc = 1'b0;

        // Resume at the stalled address
        wait_instr = 1'b0;
        step();
        check_head("resume", 32'h14, 1'b0);
        check("resume_fetch_addr", fetch_addr, 32'h18);

        // Redirect to 0, then fault on 0x8
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        check_empty("redir0");
        check("redir0_fetch_addr", fetch_addr, 32'h0);
        seg_en = 1'b1;
        seg_pc = 32'h8;
        step(5);
        check("segv_fetch_addr", fetch_addr, 32'h8);
        check_head("segv_head", 32'h0, 1'b0);
        pc_inc = 1'b1;
        step();
        check_head("segv_pop1", 32'h4, 1'b0);
        step();
        check_head("segv_pop2", 32'h8, 1'b1);
        step();
        check_empty("segv_halted");
        check("segv_hold_addr", fetch_addr, 32'h8);
        pc_inc = 1'b0;
        seg_en = 1'b0;

        // Redirect to handler clears halt
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check_empty("handler_flush");
        check("handler_fetch_addr", fetch_addr, 32'h100);
        step();
        check_head("handler_first", 32'h100, 1'b0);
        check("handler_next_addr", fetch_addr, 32'h104);

        // Redirect together with pc_inc and a returning word
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        pc_inc      = 1'b1;
        step();
        redirect = 1'b0;
        pc_inc   = 1'b0;
        check_empty("redir_pop");
        check("redir_pop_fetch_addr", fetch_addr, 32'h200);

`ifdef PREFETCH_STATS_EN
        check("flush_count", 32'(flush_count), 32'd3);
`endif

        // Queue 3 entries, stall, then asynchronous reset between edges
        step(3);
        wait_instr = 1'b1;
        step();
        check_head("pre_rst", 32'h200, 1'b0);
        check("pre_rst_fetch_addr", fetch_addr, 32'h20C);
        #2;
        rst_n = 1'b0;
        #1;
        check_empty("async_rst");
        check("async_rst_fetch_addr", fetch_addr, 32'h0);
`ifdef PREFETCH_STATS_EN
        check("async_rst_flush_count", 32'(flush_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
